// File: rtl/cdc_src_pacer.sv
// cdc_src_pacer: queues bursty single-cycle source events in a small FIFO and
// releases them one at a time as out_pulse/out_data. Each release is followed by
// a programmable idle gap, so the downstream pulse/data CDC handshake can finish
// before the next word arrives. Single clock domain (CDC source clock).
//
// Ports:
//   clk          block clock (CDC source clock)
//   reset_i      synchronous, active-high reset
//   clear_error  clears the sticky overflow flag
//   gap_cycles   idle cycles inserted after each out_pulse (captured at pop)
//   in_valid     event strobe, one event per high cycle
//   in_data      event payload, sampled with in_valid
//   out_pulse    single-cycle release strobe
//   out_data     released payload, held until the next out_pulse
//   fifo_count   entries currently queued (0..DEPTH)
//   overflow     sticky: an event was dropped because the FIFO was full
//   idle         no release in progress and nothing queued
module cdc_src_pacer #(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pDEPTH_BITS = 3,
    parameter int unsigned pGAP_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   clear_error,
    input  logic [pGAP_WIDTH-1:0]  gap_cycles,
    input  logic                   in_valid,
    input  logic [pDATA_WIDTH-1:0] in_data,
    output logic                   out_pulse,
    output logic [pDATA_WIDTH-1:0] out_data,
    output logic [pDEPTH_BITS:0]   fifo_count,
    output logic                   overflow,
    output logic                   idle
);

    localparam int unsigned DEPTH   = 2 ** pDEPTH_BITS;
    localparam int unsigned PTR_W   = pDEPTH_BITS;
    localparam int unsigned COUNT_W = pDEPTH_BITS + 1;
    localparam int unsigned GAP_W   = pGAP_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 state;
    logic [GAP_W-1:0]       gap_cnt;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [pDATA_WIDTH-1:0] mem [DEPTH];

    logic                   full_c;
    logic                   pop_c;
    logic                   push_c;
    logic                   drop_c;
    logic [COUNT_W-1:0]     count_nxt_c;

    // Pop only from IDLE; a full FIFO still accepts an event when a pop frees a slot.
    assign full_c = (fifo_count == COUNT_W'(DEPTH));
    assign pop_c  = (state == ST_IDLE) && (fifo_count != '0);
    assign push_c = in_valid && (!full_c || pop_c);
    assign drop_c = in_valid && full_c && !pop_c;

    // Occupancy after this cycle's push/pop; also feeds the registered idle flag.
    always_comb begin
        count_nxt_c = fifo_count;
        case ({push_c, pop_c})
            2'b10:   count_nxt_c = fifo_count + COUNT_W'(1);
            2'b01:   count_nxt_c = fifo_count - COUNT_W'(1);
            default: count_nxt_c = fifo_count;
        endcase
    end

    // Payload storage; no reset needed since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the release FSM.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            out_pulse  <= 1'b0;
            out_data   <= '0;
            idle       <= 1'b1;
        end else begin
            fifo_count <= count_nxt_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // A drop coinciding with clear_error keeps the flag set.
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clear_error) begin
                overflow <= 1'b0;
            end

            out_pulse <= 1'b0;
            idle      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        out_data  <= mem[rd_ptr];
                        out_pulse <= 1'b1;
                        gap_cnt   <= gap_cycles;
                        state     <= ST_PULSE;
                    end else begin
                        idle <= (count_nxt_c == '0);
                    end
                end
                ST_PULSE: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        idle  <= (count_nxt_c == '0);
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= ST_IDLE;
                        idle  <= (count_nxt_c == '0);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_src_pacer.sv
// Directed bench for cdc_src_pacer: accepted payloads go into a scoreboard queue
// and are matched against each out_pulse; release cycles are recorded and checked
// against the expected gap spacing.
module tb_cdc_src_pacer;

    logic       clk;
    logic       reset_i;
    logic       clear_error;
    logic [7:0] gap_cycles;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_pulse;
    logic [7:0] out_data;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       idle;

    int         n_checks;
    int         n_errors;
    int         cyc;
    logic [7:0] exp_q[$];
    int         pulses[$];
    logic [7:0] last_data;
    logic       prev_pulse;
    logic       mon_en;

    cdc_src_pacer #(
        .pDATA_WIDTH(8),
        .pDEPTH_BITS(3),
        .pGAP_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .clear_error(clear_error),
        .gap_cycles (gap_cycles),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_pulse  (out_pulse),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        reset_i = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst out_pulse", 32'(out_pulse), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst fifo_count", 32'(fifo_count), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst idle", 32'(idle), 32'd1);
        reset_i = 1'b0;
        exp_q.delete();
        pulses.delete();
        last_data = 8'h00;
        mon_en    = 1'b1;
    endtask

    task automatic chk_pulse(input string tag, input int idx, input int exp_cyc);
        int obs;
        obs = (idx < pulses.size()) ? pulses[idx] : -1;
        chk(tag, 32'(obs), 32'(exp_cyc));
    endtask

    // Scoreboard monitor: every release must match the oldest accepted payload,
    // be a single cycle wide, and out_data must hold between releases.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_pulse = 1'b0;
        end else begin
            if (out_pulse) begin
                chk("pulse_width", 32'(prev_pulse), 32'd0);
                chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    last_data = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(last_data));
                end
                pulses.push_back(cyc);
            end else begin
                chk("data_hold", 32'(out_data), 32'(last_data));
            end
            prev_pulse = out_pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_checks    = 0;
        n_errors    = 0;
        mon_en      = 1'b0;
        prev_pulse  = 1'b0;
        last_data   = 8'h00;
        reset_i     = 1'b1;
        clear_error = 1'b0;
        gap_cycles  = 8'd0;
        in_valid    = 1'b0;
        in_data     = 8'h00;

        // Reset state
        do_reset();

        // Single event, gap 4: pulse two cycles after the strobe, idle again at +7
        gap_cycles = 8'd4;
        step();
        n = cyc;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        step();
        in_valid = 1'b0;
        wait_cyc(n + 6);
        @(negedge clk);
        chk("t2 idle_during_gap", 32'(idle), 32'd0);
        step();
        @(negedge clk);
        chk("t2 idle_after_gap", 32'(idle), 32'd1);
        chk("t2 pulse_count", 32'(pulses.size()), 32'd1);
        chk_pulse("t2 pulse_cycle", 0, n + 2);
        chk("t2 out_data_held", 32'(out_data), 32'hA5);
        pulses.delete();

        // Five back-to-back events, gap 3: 5-cycle release spacing, in order
        gap_cycles = 8'd3;
        step();
        n = cyc;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            exp_q.push_back(8'(i + 1));
            step();
        end
        in_valid = 1'b0;
        wait_cyc(n + 28);
        @(negedge clk);
        chk("t3 pulse_count", 32'(pulses.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk_pulse("t3 pulse_cycle", i, n + 2 + 5 * i);
        chk("t3 idle", 32'(idle), 32'd1);
        chk("t3 scoreboard_drained", 32'(exp_q.size()), 32'd0);
        pulses.delete();

        // Overflow: 10 events into a long gap, 10th dropped; clear; drop+clear
        gap_cycles = 8'd255;
        step();
        n = cyc;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            if (i < 9) exp_q.push_back(8'(8'h10 + i));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4 overflow_set", 32'(overflow), 32'd1);
        chk("t4 fifo_full", 32'(fifo_count), 32'd8);
        chk("t4 pulse_count", 32'(pulses.size()), 32'd1);
        chk_pulse("t4 pulse_cycle", 0, n + 2);
        clear_error = 1'b1;
        step();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        chk("t4 overflow_cleared", 32'(overflow), 32'd0);
        step();
        in_valid    = 1'b0;
        clear_error = 1'b0;
        @(negedge clk);
        chk("t4 drop_wins_clear", 32'(overflow), 32'd1);
        chk("t4 fifo_still_full", 32'(fifo_count), 32'd8);
        step();
        @(negedge clk);
        chk("t4 overflow_sticky", 32'(overflow), 32'd1);
        do_reset();

        // Gap 0: releases every 2 cycles
        gap_cycles = 8'd0;
        step();
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h21 + i);
            exp_q.push_back(8'(8'h21 + i));
            step();
        end
        in_valid = 1'b0;
        wait_cyc(n + 9);
        @(negedge clk);
        chk("t5 pulse_count", 32'(pulses.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk_pulse("t5 pulse_cycle", i, n + 2 + 2 * i);
        pulses.delete();

        // Gap change mid-GAP affects only the following release
        gap_cycles = 8'd2;
        step();
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + i);
            exp_q.push_back(8'(8'h31 + i));
            step();
        end
        in_valid   = 1'b0;
        gap_cycles = 8'd6;
        wait_cyc(n + 17);
        @(negedge clk);
        chk("t5b pulse_count", 32'(pulses.size()), 32'd3);
        chk_pulse("t5b pulse0", 0, n + 2);
        chk_pulse("t5b pulse1_gap2", 1, n + 6);
        chk_pulse("t5b pulse2_gap6", 2, n + 14);
        pulses.delete();

        // Reset mid-GAP with three entries queued
        gap_cycles = 8'd20;
        step();
        n = cyc;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h41 + i);
            exp_q.push_back(8'(8'h41 + i));
            step();
        end
        in_valid = 1'b0;
        wait_cyc(n + 6);
        @(negedge clk);
        chk("t6 queued_before_reset", 32'(fifo_count), 32'd3);
        chk("t6 busy_before_reset", 32'(idle), 32'd0);
        mon_en  = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("t6 fifo_flushed", 32'(fifo_count), 32'd0);
        chk("t6 idle_after_reset", 32'(idle), 32'd1);
        chk("t6 out_data_reset", 32'(out_data), 32'd0);
        exp_q.delete();
        pulses.delete();
        last_data = 8'h00;
        mon_en    = 1'b1;
        wait_cyc(n + 45);
        @(negedge clk);
        chk("t6 no_release_after_reset", 32'(pulses.size()), 32'd0);
        chk("t6 still_idle", 32'(idle), 32'd1);
        chk("t6 overflow_clear", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
